// File: rtl/phy_rx_lane_align.sv
// Per-lane serial-to-parallel converter with sliding-window COM (comma) byte alignment.
// Locks after COM_COUNT consecutive aligned COMs, then delivers one byte every 8 clk_32f cycles.
module phy_rx_lane_align #(
   parameter int         COM_COUNT = 4,
   parameter logic [7:0] COM_SYM   = 8'hBC
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       active,
   output logic       com_det
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      COUNT  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_CNT = 4'(COM_COUNT);

   state_t     state;
   logic [7:0] sr;
   logic [2:0] bit_cnt;
   logic [3:0] com_cnt;
   logic [7:0] nxt;
   logic       is_com;
   logic       boundary;

   // The candidate byte includes the bit being sampled on this edge, so a byte is
   // recognised on the same edge that delivers its LSB.
   assign nxt      = {sr[6:0], data_in};
   assign is_com   = (nxt == COM_SYM);
   assign boundary = (bit_cnt == 3'd7);

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state      <= SEARCH;
         sr         <= '0;
         bit_cnt    <= '0;
         com_cnt    <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         active     <= 1'b0;
         com_det    <= 1'b0;
      end else begin
         sr         <= nxt;
         byte_valid <= 1'b0;
         com_det    <= 1'b0;
         case (state)
            SEARCH: begin
               // Sliding window: any bit position may start a byte until a COM matches.
               if (is_com) begin
                  bit_cnt <= '0;
                  com_cnt <= 4'd1;
                  com_det <= 1'b1;
                  if (COM_COUNT == 1) begin
                     state  <= ACTIVE;
                     active <= 1'b1;
                  end else begin
                     state <= COUNT;
                  end
               end
            end
            COUNT: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (boundary) begin
                  if (is_com) begin
                     com_cnt <= com_cnt + 4'd1;
                     com_det <= 1'b1;
                     if (com_cnt + 4'd1 == LOCK_CNT) begin
                        state  <= ACTIVE;
                        active <= 1'b1;
                     end
                  end else begin
                     com_cnt <= '0;
                     state   <= SEARCH;
                  end
               end
            end
            ACTIVE: begin
               // Lock is held until reset; in-band COMs are idles and never delivered.
               bit_cnt <= bit_cnt + 3'd1;
               if (boundary) begin
                  if (is_com) begin
                     com_det <= 1'b1;
                  end else begin
                     byte_out   <= nxt;
                     byte_valid <= 1'b1;
                  end
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

endmodule

// File: tb/tb_phy_rx_lane_align.sv
// Self-checking bench for phy_rx_lane_align: directed vector table, hand-written corner
// sequences, and randomized bit streams checked against a stream-level alignment model.
module tb_phy_rx_lane_align;

   localparam int         COM_COUNT = 4;
   localparam logic [7:0] COM       = 8'hBC;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] byte_out,   byte_out_1;
   logic       byte_valid, byte_valid_1;
   logic       active,     active_1;
   logic       com_det,    com_det_1;
   logic [3:0] dly;

   always #5 clk_32f = ~clk_32f;

   // Lane 1 sees the lane 0 stream four bit times later.
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) dly <= '0;
      else        dly <= {dly[2:0], data_in};
   end

   phy_rx_lane_align #(.COM_COUNT(COM_COUNT), .COM_SYM(COM)) u_lane0 (
      .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
      .byte_out(byte_out), .byte_valid(byte_valid), .active(active), .com_det(com_det)
   );

   phy_rx_lane_align #(.COM_COUNT(COM_COUNT), .COM_SYM(COM)) u_lane1 (
      .clk_32f(clk_32f), .reset(reset), .data_in(dly[3]),
      .byte_out(byte_out_1), .byte_valid(byte_valid_1), .active(active_1), .com_det(com_det_1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int         cyc;
   int         act_cyc;
   int         v_cyc[$];
   logic [7:0] v_byte[$];
   int         c_cyc[$];
   int         v1_cyc[$];
   logic [7:0] v1_byte[$];

   bit         rb[$];
   logic [10:0] rexp[$];
   logic [10:0] robs[$];

   typedef struct {
      string       name;
      int          lead_n;
      logic [7:0]  lead;
      int          nbytes;
      logic [95:0] bytes;
      int          exp_nvalid;
      logic [31:0] exp_bytes;
      int          exp_ncom;
      logic        exp_active;
      int          exp_gap;
      int          exp_first;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      v_cyc.delete(); v_byte.delete(); c_cyc.delete();
      v1_cyc.delete(); v1_byte.delete();
      cyc = 0;
      act_cyc = -1;
   endtask

   task automatic tick(input logic b);
      data_in = b;
      @(posedge clk_32f);
      #1;
      if (byte_valid) begin v_cyc.push_back(cyc); v_byte.push_back(byte_out); end
      if (com_det) c_cyc.push_back(cyc);
      if (active && act_cyc < 0) act_cyc = cyc;
      if (byte_valid_1) begin v1_cyc.push_back(cyc); v1_byte.push_back(byte_out_1); end
      check("valid_com_exclusive", int'(byte_valid & com_det), 0);
      check("valid_only_when_active", int'(byte_valid & ~active), 0);
      cyc++;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) tick(b[i]);
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      data_in = 1'b0;
      repeat (2) @(posedge clk_32f);
      #1;
      check("reset_byte_out", int'(byte_out), 0);
      check("reset_byte_valid", int'(byte_valid), 0);
      check("reset_active", int'(active), 0);
      check("reset_com_det", int'(com_det), 0);
      clear_log();
      reset = 1'b1;
   endtask

   function automatic int win(input int t);
      int w;
      w = 0;
      for (int k = t - 7; k <= t; k++)
         w = (w << 1) | ((k >= 0 && k < rb.size()) ? int'(rb[k]) : 0);
      return w & 255;
   endfunction

   // Reference: find the first COM anywhere in the bit history, then demand COM_COUNT
   // COMs at 8-bit spacing; a break restarts the scan one bit after the failing byte.
   task automatic model_run();
      int n, t, cnt, act_from, hold;
      bit vld[];
      bit cd[];
      int by[];
      n        = rb.size();
      act_from = n;
      t        = 0;
      vld = new[n];
      cd  = new[n];
      by  = new[n];
      while (t < n) begin
         if (win(t) != int'(COM)) begin
            t++;
            continue;
         end
         cd[t] = 1'b1;
         cnt   = 1;
         while (cnt < COM_COUNT && t + 8 < n && win(t + 8) == int'(COM)) begin
            t += 8;
            cd[t] = 1'b1;
            cnt++;
         end
         if (cnt == COM_COUNT) begin
            act_from = t;
            break;
         end
         if (t + 8 >= n) break;
         t += 9;
      end
      if (act_from < n) begin
         for (int u = act_from + 8; u < n; u += 8) begin
            if (win(u) == int'(COM)) cd[u] = 1'b1;
            else begin vld[u] = 1'b1; by[u] = win(u); end
         end
      end
      rexp.delete();
      hold = 0;
      for (int u = 0; u < n; u++) begin
         if (vld[u]) hold = by[u];
         rexp.push_back({(u >= act_from), cd[u], vld[u], 8'(hold)});
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) rb.push_back(b[i]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lead, ncom, nd;
      logic [7:0] rbyte;

      vecs[0] = '{"lock_then_data", 0, 8'h00, 9, 96'hBCBCBCBC_AAAA5555_BC000000,
                  4, 32'hAAAA5555, 5, 1'b1, 8, 39};
      vecs[1] = '{"break_before_lock", 0, 8'h00, 6, 96'hBCBCBC66_00000000_00000000,
                  0, 32'h0, 3, 1'b0, 0, -1};
      vecs[2] = '{"bit_offset_align", 3, 8'b100, 7, 96'hBCBCBCBC_6633BC00_00000000,
                  2, 32'h66330000, 5, 1'b1, 8, 42};
      vecs[3] = '{"com_in_data", 0, 8'h00, 8, 96'hBCBCBCBC_AABCDDBC_00000000,
                  2, 32'hAADD0000, 6, 1'b1, 16, 39};

      for (int i = 0; i < 4; i++) begin
         do_reset();
         for (int k = vecs[i].lead_n - 1; k >= 0; k--) tick(vecs[i].lead[k]);
         for (int j = 0; j < vecs[i].nbytes; j++) send_byte(vecs[i].bytes[95 - 8*j -: 8]);
         check({vecs[i].name, "_nvalid"}, v_cyc.size(), vecs[i].exp_nvalid);
         check({vecs[i].name, "_ncom"}, c_cyc.size(), vecs[i].exp_ncom);
         check({vecs[i].name, "_active"}, int'(active), int'(vecs[i].exp_active));
         check({vecs[i].name, "_first_strobe"}, (v_cyc.size() > 0) ? v_cyc[0] : -1,
               vecs[i].exp_first);
         for (int k = 0; k < vecs[i].exp_nvalid; k++)
            check({vecs[i].name, "_byte"}, (k < v_byte.size()) ? int'(v_byte[k]) : -1,
                  int'(vecs[i].exp_bytes[31 - 8*k -: 8]));
         if (vecs[i].exp_nvalid >= 2)
            check({vecs[i].name, "_gap"}, (v_cyc.size() >= 2) ? v_cyc[1] - v_cyc[0] : -1,
                  vecs[i].exp_gap);
         if (vecs[i].exp_active) begin
            check({vecs[i].name, "_lock_at_com"}, act_cyc,
                  (c_cyc.size() >= COM_COUNT) ? c_cyc[COM_COUNT-1] : -2);
            check({vecs[i].name, "_first_after_lock"},
                  (v_cyc.size() > 0) ? v_cyc[0] - act_cyc : -1, 8);
         end
      end

      // COM in the data stream: byte_out must keep the previous data byte.
      do_reset();
      repeat (4) send_byte(COM);
      send_byte(8'hAA);
      send_byte(COM);
      check("idle_com_det", int'(com_det), 1);
      check("idle_no_valid", int'(byte_valid), 0);
      check("idle_byte_hold", int'(byte_out), 8'hAA);

      // Async reset mid-byte in ACTIVE, then data without COMs must not be delivered.
      do_reset();
      repeat (4) send_byte(COM);
      send_byte(8'hAA);
      tick(1'b0); tick(1'b1); tick(1'b0);
      check("pre_reset_active", int'(active), 1);
      #3;
      reset = 1'b0;
      #1;
      check("async_byte_out", int'(byte_out), 0);
      check("async_active", int'(active), 0);
      check("async_byte_valid", int'(byte_valid), 0);
      check("async_com_det", int'(com_det), 0);
      repeat (2) @(posedge clk_32f);
      #1;
      clear_log();
      reset = 1'b1;
      send_byte(8'hAA); send_byte(8'h55); send_byte(8'hAA); send_byte(8'h55);
      check("post_reset_nvalid", v_cyc.size(), 0);
      check("post_reset_active", int'(active), 0);

      // Two lanes, lane 1 delayed by four bits.
      do_reset();
      repeat (4) send_byte(COM);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      send_byte(COM);
      check("lane0_active", int'(active), 1);
      check("lane1_active", int'(active_1), 1);
      check("lane0_nvalid", v_cyc.size(), 3);
      check("lane1_nvalid", v1_cyc.size(), 3);
      for (int k = 0; k < 3; k++) begin
         check("lane_skew", (k < v1_cyc.size() && k < v_cyc.size()) ? v1_cyc[k] - v_cyc[k] : -1, 4);
         check("lane1_byte", (k < v1_byte.size()) ? int'(v1_byte[k]) : -1,
               (k == 0) ? 8'h12 : (k == 1) ? 8'h34 : 8'h56);
         check("lane0_byte", (k < v_byte.size()) ? int'(v_byte[k]) : -1,
               (k == 0) ? 8'h12 : (k == 1) ? 8'h34 : 8'h56);
      end

      // Randomized streams against the reference model, compared every cycle.
      for (int trial = 0; trial < 24; trial++) begin
         rb.delete();
         lead = $urandom_range(0, 20);
         for (int k = 0; k < lead; k++) rb.push_back(1'($urandom_range(0, 1)));
         ncom = $urandom_range(2, 6);
         for (int k = 0; k < ncom; k++) push_byte(COM);
         nd = $urandom_range(4, 10);
         for (int k = 0; k < nd; k++) begin
            rbyte = ($urandom_range(0, 4) == 0) ? COM : 8'($urandom_range(0, 255));
            push_byte(rbyte);
         end
         model_run();
         do_reset();
         robs.delete();
         for (int t = 0; t < rb.size(); t++) begin
            tick(rb[t]);
            robs.push_back({active, com_det, byte_valid, byte_out});
         end
         for (int t = 0; t < rb.size(); t++)
            check("random_cycle", int'(robs[t]), int'(rexp[t]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
